gain_ramp_sequencer: RTL and testbench

- Drives the control inputs of the effects pipeline: generates the one-cycle sample strobe (valid) from a clock divider and supplies the gain parameter (i_par_gain).
- Gain changes are rate-limited: the applied gain moves toward a host-programmed target by at most ramp_step per sample. This prevents zipper noise.
- Provides mute, which ramps the applied gain to 0 and back to the stored target.
- Sits between the host/control-register logic and the pipeline instance.

---
 rtl/gain_ramp_sequencer.sv | 81 ++++++++
 tb/tb_gain_ramp_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gain_ramp_sequencer.sv
// gain_ramp_sequencer: sample strobe divider plus rate-limited, mutable gain for the effects pipeline
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-low
//   i_target_gain  requested gain (unsigned, latched by i_target_load)
//   i_target_load  single-cycle load strobe for i_target_gain
//   i_mute         level; forces the effective target to 0 while high
//   o_valid        one-cycle sample strobe, every clk_div cycles
//   o_gain         applied gain, moves at most ramp_step per sample
//   o_busy         high while o_gain is still moving toward the effective target
//   o_state        0 idle, 1 ramping up, 2 ramping down
module gain_ramp_sequencer #(
    parameter int gain_width = 11,
    parameter int clk_div    = 1024,
    parameter int ramp_step  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [gain_width-1:0] i_target_gain,
    input  logic                  i_target_load,
    input  logic                  i_mute,
    output logic                  o_valid,
    output logic [gain_width-1:0] o_gain,
    output logic                  o_busy,
    output logic [1:0]            o_state
);
    localparam int              CW     = $clog2(clk_div);
    localparam logic [1:0]      S_IDLE = 2'd0;
    localparam logic [1:0]      S_UP   = 2'd1;
    localparam logic [1:0]      S_DOWN = 2'd2;
    localparam logic [CW-1:0]   LAST   = CW'(clk_div - 1);
    localparam logic [gain_width:0] STEP = (gain_width + 1)'(ramp_step);

    logic [CW-1:0]         r_count;
    logic [gain_width-1:0] r_target;

    logic [CW-1:0]         w_count_nxt;
    logic [gain_width-1:0] w_target_nxt;
    logic [gain_width:0]   w_eff;
    logic [gain_width:0]   w_cur;
    logic [gain_width:0]   w_diff;
    logic                  w_up;
    logic [gain_width-1:0] w_gain_nxt;
    logic [gain_width:0]   w_eff_nxt;
    logic [1:0]            w_state_nxt;

    // Arithmetic is one bit wider than the gain so differences never wrap.
    // o_valid marks the tick cycle, so the gain moves only on the edge ending it;
    // the state looks at next-cycle target and gain so it settles with o_gain.
    always_comb begin
        w_count_nxt  = (r_count == LAST) ? '0 : r_count + 1'b1;
        w_target_nxt = i_target_load ? i_target_gain : r_target;
        w_eff        = i_mute ? '0 : {1'b0, r_target};
        w_cur        = {1'b0, o_gain};
        w_up         = w_eff > w_cur;
        w_diff       = w_up ? w_eff - w_cur : w_cur - w_eff;
        w_gain_nxt   = !o_valid ? o_gain :
                       gain_width'((w_diff <= STEP) ? w_eff : w_up ? w_cur + STEP : w_cur - STEP);
        w_eff_nxt    = i_mute ? '0 : {1'b0, w_target_nxt};
        w_state_nxt  = (w_eff_nxt > {1'b0, w_gain_nxt}) ? S_UP :
                       (w_eff_nxt < {1'b0, w_gain_nxt}) ? S_DOWN : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_target <= '0;
            o_valid  <= 1'b0;
            o_gain   <= '0;
            o_state  <= S_IDLE;
            o_busy   <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            o_valid  <= (w_count_nxt == LAST);
            o_gain   <= w_gain_nxt;
            o_state  <= w_state_nxt;
            o_busy   <= (w_state_nxt != S_IDLE);
        end
    end
endmodule

// File: tb/tb_gain_ramp_sequencer.sv
// tb_gain_ramp_sequencer: directed stimulus with an arithmetic reference model and literal checkpoints
module tb_gain_ramp_sequencer;
    localparam int GW = 11;
    localparam int CD = 4;
    localparam int RS = 2;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic [GW-1:0] tg   = '0;
    logic          ld   = 1'b0;
    logic          mute = 1'b0;
    logic          o_valid;
    logic [GW-1:0] o_gain;
    logic          o_busy;
    logic [1:0]    o_state;

    int n_pass  = 0;
    int n_total = 0;
    bit run     = 1'b0;

    int m_cyc = 0, m_target = 0, m_gain = 0, m_state = 0, prev_gain = 0;

    always #5 clk = ~clk;

    gain_ramp_sequencer #(.gain_width(GW), .clk_div(CD), .ramp_step(RS)) dut (
        .clk(clk), .rst(rst), .i_target_gain(tg), .i_target_load(ld), .i_mute(mute),
        .o_valid(o_valid), .o_gain(o_gain), .o_busy(o_busy), .o_state(o_state)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int ramp(input int g, input int e);
        return (e - g > RS) ? g + RS : (g - e > RS) ? g - RS : e;
    endfunction

    function automatic int ngain();
        return (m_cyc % CD == CD - 1) ? ramp(m_gain, mute ? 0 : m_target) : m_gain;
    endfunction

    function automatic int dir(input int e, input int g);
        return e > g ? 1 : e < g ? 2 : 0;
    endfunction

    // Reference model: cycle count since reset release, stored target, gain moved once per sample.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc    <= 0;
            m_target <= 0;
            m_gain   <= 0;
            m_state  <= 0;
        end else begin
            m_cyc    <= m_cyc + 1;
            m_target <= ld ? int'(tg) : m_target;
            m_gain   <= ngain();
            m_state  <= dir(mute ? 0 : (ld ? int'(tg) : m_target), ngain());
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("valid", int'(o_valid), int'(rst && (m_cyc % CD == CD - 1)));
            chk("gain", int'(o_gain), m_gain);
            chk("state", int'(o_state), m_state);
            chk("busy", int'(o_busy), int'(m_state != 0));
            if (o_valid) chk("gain_stable_on_valid", int'(o_gain), prev_gain);
            prev_gain <= int'(o_gain);
        end
    end

    initial begin
        #3 rst = 1'b0;
        run = 1'b1;
        go(2);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk("t1_valid", int'(o_valid), int'(c % 4 == 3));
            chk("t1_gain", int'(o_gain), 0);
            chk("t1_state", int'(o_state), 0);
            chk("t1_busy", int'(o_busy), 0);
            go(1);
        end
        tg = 5; ld = 1'b1; go(1); ld = 1'b0;
        chk("t2_state_up", int'(o_state), 1);
        chk("t2_busy", int'(o_busy), 1);
        go(3);  chk("t2_gain_2", int'(o_gain), 2);
        go(4);  chk("t2_gain_4", int'(o_gain), 4);
        go(4);  chk("t2_gain_5", int'(o_gain), 5);
        chk("t2_idle", int'(o_state), 0);
        chk("t2_not_busy", int'(o_busy), 0);
        tg = 0; ld = 1'b1; go(1); ld = 1'b0;
        chk("down_state", int'(o_state), 2);
        go(11); chk("down_gain_0", int'(o_gain), 0);
        chk("down_idle", int'(o_state), 0);
        tg = 10; ld = 1'b1; go(1); ld = 1'b0;
        go(11); chk("t3_gain_6", int'(o_gain), 6);
        chk("t3_state_up", int'(o_state), 1);
        tg = 3; ld = 1'b1; go(1); ld = 1'b0;
        chk("t3_reverse", int'(o_state), 2);
        go(3);  chk("t3_gain_4", int'(o_gain), 4);
        go(4);  chk("t3_gain_3", int'(o_gain), 3);
        chk("t3_idle", int'(o_state), 0);
        tg = 8; ld = 1'b1; go(1); ld = 1'b0;
        go(11); chk("t4_gain_8", int'(o_gain), 8);
        chk("t4_idle", int'(o_state), 0);
        mute = 1'b1; go(1);
        chk("t4_mute_down", int'(o_state), 2);
        go(3);  chk("t4_mute_6", int'(o_gain), 6);
        go(4);  chk("t4_mute_4", int'(o_gain), 4);
        go(4);  chk("t4_mute_2", int'(o_gain), 2);
        go(4);  chk("t4_mute_0", int'(o_gain), 0);
        chk("t4_muted_idle", int'(o_state), 0);
        mute = 1'b0; go(1);
        chk("t4_unmute_up", int'(o_state), 1);
        go(3);  chk("t4_unmute_2", int'(o_gain), 2);
        go(12); chk("t4_unmute_8", int'(o_gain), 8);
        chk("t4_unmute_idle", int'(o_busy), 0);
        go(3);  chk("t5_tick", int'(o_valid), 1);
        tg = 7; ld = 1'b1; go(1); ld = 1'b0;
        chk("t5_gain_held", int'(o_gain), 8);
        chk("t5_state_down", int'(o_state), 2);
        go(4);  chk("t5_gain_7", int'(o_gain), 7);
        chk("t5_idle", int'(o_state), 0);
        tg = 20; ld = 1'b1; go(1); ld = 1'b0;
        go(5);  chk("t6_pre_gain", int'(o_gain), 9);
        chk("t6_pre_state", int'(o_state), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", int'(o_valid), 0);
        chk("t6_rst_gain", int'(o_gain), 0);
        chk("t6_rst_state", int'(o_state), 0);
        chk("t6_rst_busy", int'(o_busy), 0);
        go(2);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("t6_valid", int'(o_valid), int'(c == 3));
            chk("t6_gain", int'(o_gain), 0);
            chk("t6_state", int'(o_state), 0);
            go(1);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
